// File: rtl/servo_pkg.sv
// Shared types and default timing for the servo dispense controller.
// Defaults assume a 50 MHz clock and a 20 ms servo frame.
package servo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_DISPENSE,
      ST_RETURN,
      ST_DONE
   } state_t;

   localparam int DEF_N_MOTORS      = 4;
   localparam int DEF_PERIOD_CYC    = 1_000_000;
   localparam int DEF_PULSE_REST    = 50_000;
   localparam int DEF_PULSE_DISP    = 100_000;
   localparam int DEF_HOLD_FRAMES   = 50;
   localparam int DEF_RETURN_FRAMES = 25;

   // Product codes are 1-based; 0 and anything above the slot count are rejected.
   function automatic logic code_valid(input logic [2:0] code, input int unsigned n_motors);
      return (code != 3'd0) && ({29'd0, code} <= n_motors);
   endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running PWM frame counter; frame_end marks the last cycle of every frame.
module servo_frame_timer #(
   parameter  int PERIOD_CYC = servo_pkg::DEF_PERIOD_CYC,
   localparam int CW         = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic [CW-1:0] cnt,
   output logic          frame_end
);

   logic [CW-1:0] cnt_q;

   assign frame_end = (cnt_q == CW'(PERIOD_CYC - 1));
   assign cnt       = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (frame_end) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/servo_dispense_ctrl.sv
// Drives one servo per product slot: rest pulses normally, a timed sweep to the
// dispense position for the selected slot, then reports completion.
module servo_dispense_ctrl
   import servo_pkg::*;
#(
   parameter int N_MOTORS      = DEF_N_MOTORS,
   parameter int PERIOD_CYC    = DEF_PERIOD_CYC,
   parameter int PULSE_REST    = DEF_PULSE_REST,
   parameter int PULSE_DISP    = DEF_PULSE_DISP,
   parameter int HOLD_FRAMES   = DEF_HOLD_FRAMES,
   parameter int RETURN_FRAMES = DEF_RETURN_FRAMES
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sel_valid,
   input  logic [2:0]          sel_code,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [N_MOTORS-1:0] pwm_motor
);

   localparam int CW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
   localparam int IW = (N_MOTORS > 1) ? $clog2(N_MOTORS) : 1;
   localparam int FMAX = (HOLD_FRAMES > RETURN_FRAMES) ? HOLD_FRAMES : RETURN_FRAMES;
   localparam int FW = (FMAX > 0) ? $clog2(FMAX + 1) : 1;

   localparam logic [CW-1:0] W_REST = CW'(PULSE_REST);
   localparam logic [CW-1:0] W_DISP = CW'(PULSE_DISP);

   logic [CW-1:0]       cnt;
   logic                frame_end;
   state_t              state_q;
   logic [IW-1:0]       idx_q;
   logic [IW-1:0]       idx_d;
   logic [FW-1:0]       frames_q;
   logic [CW-1:0]       width_q [N_MOTORS];
   logic [N_MOTORS-1:0] pwm_q;
   logic                busy_q;
   logic                done_q;
   logic                error_q;
   logic                code_ok;

   servo_frame_timer #(
      .PERIOD_CYC (PERIOD_CYC)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .cnt       (cnt),
      .frame_end (frame_end)
   );

   assign code_ok = code_valid(sel_code, N_MOTORS);
   assign idx_d   = IW'(sel_code - 3'd1);

   // Widths only move on frame_end, so each comparator sees one width per frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         frames_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         for (int i = 0; i < N_MOTORS; i++) begin
            width_q[i] <= W_REST;
         end
      end else begin
         done_q  <= 1'b0;
         error_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (sel_valid) begin
                  if (code_ok) begin
                     idx_q   <= idx_d;
                     busy_q  <= 1'b1;
                     state_q <= ST_ARM;
                  end else begin
                     error_q <= 1'b1;
                  end
               end
            end
            ST_ARM: begin
               if (frame_end) begin
                  width_q[idx_q] <= W_DISP;
                  frames_q       <= '0;
                  state_q        <= ST_DISPENSE;
               end
            end
            ST_DISPENSE: begin
               if (frame_end) begin
                  if (frames_q == FW'(HOLD_FRAMES - 1)) begin
                     width_q[idx_q] <= W_REST;
                     frames_q       <= '0;
                     state_q        <= ST_RETURN;
                  end else begin
                     frames_q <= frames_q + FW'(1);
                  end
               end
            end
            ST_RETURN: begin
               if (frame_end) begin
                  if (frames_q == FW'(RETURN_FRAMES - 1)) begin
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end else begin
                     frames_q <= frames_q + FW'(1);
                  end
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Registered compare: each pulse rises the cycle after cnt==0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_q <= '0;
      end else begin
         for (int i = 0; i < N_MOTORS; i++) begin
            pwm_q[i] <= (cnt < width_q[i]);
         end
      end
   end

   assign pwm_motor = pwm_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule

// File: doc/servo_dispense_ctrl.md
Name: servo_dispense_ctrl

Overview:
Downstream stage of the product-selection/PWM counter logic. It takes a validated product code from the selection FSM and drives one hobby servo per product slot with a standard 20 ms frame PWM. The selected servo sweeps to the dispense position for a fixed number of frames, then returns to rest, and completion is reported back to the selection/LCD FSM.

Parameters:
N_MOTORS, 4, number of servos/product slots; valid codes are 1..N_MOTORS
PERIOD_CYC, 1_000_000, PWM frame length in clk cycles (20 ms at 50 MHz)
PULSE_REST, 50_000, high time for the rest position (1 ms)
PULSE_DISP, 100_000, high time for the dispense position (2 ms); must be < PERIOD_CYC
HOLD_FRAMES, 50, frames held at the dispense position (1 s)
RETURN_FRAMES, 25, frames at rest before done is reported (0.5 s)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
sel_valid  in  1  one-cycle request strobe from the selection FSM
sel_code  in  3  product code, sampled when sel_valid=1
busy  out  1  high from the cycle after acceptance through the DONE cycle
done  out  1  one-cycle pulse at the end of the dispense cycle
error  out  1  one-cycle pulse when an invalid code is requested in IDLE
pwm_motor  out  N_MOTORS  servo PWM, bit i drives the servo for code i+1

Behaviour:
- Reset (async assert, sync release): cnt=0; state=IDLE; all width regs=PULSE_REST; pwm_motor=0, busy=0, done=0, error=0.
- Frame counter cnt: 0..PERIOD_CYC-1, then wraps to 0. frame_end = (cnt==PERIOD_CYC-1). Counter width is clog2(PERIOD_CYC), which is 20 bits at the default.
- PWM: pwm_motor[i] is registered as (cnt < width_i). Each bit is high for exactly width_i cycles per frame and rises one cycle after cnt==0. width_i changes only on frame_end, so there are no runt or stretched pulses.
- Idle servos always receive PULSE_REST pulses so they hold position.
- FSM states: IDLE, ARM, DISPENSE, RETURN, DONE.
  - IDLE: if sel_valid and 1<=sel_code<=N_MOTORS, latch idx=sel_code-1 and go to ARM (busy=1 next cycle). If sel_valid with code 0 or >N_MOTORS, pulse error for one cycle (next cycle) and stay IDLE.
  - ARM: wait for the first frame_end strictly after acceptance. At that frame_end set width_idx=PULSE_DISP, frames=0, go to DISPENSE. If accepted on a frame_end cycle, ARM waits a full frame.
  - DISPENSE: at each frame_end increment frames. On the HOLD_FRAMES-th frame_end set width_idx=PULSE_REST, frames=0, go to RETURN.
  - RETURN: on the RETURN_FRAMES-th frame_end go to DONE.
  - DONE: done=1 and busy=1 for this single cycle, then IDLE (busy=0).
- sel_valid outside IDLE is ignored: no error, and the latched code is unchanged.
- Frame counter HOLD/RETURN width is clog2(max(HOLD_FRAMES,RETURN_FRAMES)+1).
- Reset mid-operation: all outputs drop immediately, the in-flight dispense is abandoned with no done, and rest pulses restart from cnt=0 after release.
- sel_code is only sampled in IDLE with sel_valid high; its value at other times is don't-care.

Decomposition:
- Package servo_pkg holds: the state enum (IDLE, ARM, DISPENSE, RETURN, DONE), default timing constants (PERIOD_CYC, PULSE_REST, PULSE_DISP, HOLD_FRAMES, RETURN_FRAMES), and a code-valid helper function.
- Sub-module servo_frame_timer (params PERIOD_CYC; ports clk, rst_n, cnt, frame_end) holds the free-running counter. The top level holds the FSM, the width registers and the PWM comparators.

Test Plan (sim params PERIOD_CYC=100, PULSE_REST=5, PULSE_DISP=10, HOLD_FRAMES=3, RETURN_FRAMES=2, N_MOTORS=4):
- Reset release, no requests -> every pwm_motor bit is high for exactly 5 cycles per 100, rising at cnt=1; busy=done=error=0.
- sel_valid with code 2 at cnt=40:
  - busy=1 at the next cycle.
  - pwm_motor[1] has 10-cycle pulses for 3 frames starting in the next frame, then 5-cycle pulses.
  - done pulses once on the 2nd RETURN frame_end and busy drops the cycle after.
  - Bits 0, 2 and 3 stay at 5 throughout.
- sel_valid with code 0, then with code 5 -> one error pulse each, busy stays 0, PWM unchanged.
- sel_valid with code 3 while busy with code 1 -> ignored: no error, only pwm_motor[0] sweeps, exactly one done.
- sel_valid with code 4 on a cycle with cnt=99 -> the first 10-cycle pulse on pwm_motor[3] starts in the frame after next (ARM waits a full frame).
- rst_n low during the 2nd DISPENSE frame -> pwm_motor=0 and busy=0 immediately; after release, 5-cycle pulses restart from cnt=0 and no done is ever emitted.
